// File: rtl/dm_load_unit.sv
// dm_load_unit: load-side memory access unit.
// Takes a load request from the M stage, issues a word-aligned read to a
// variable-latency data memory, waits for rd_valid (bounded by MAX_WAIT
// cycles), then zero/sign-extends the addressed byte, halfword or word.
//
//   state | meaning
//   IDLE  | no read outstanding; new request may be accepted
//   WAIT  | read issued, rd_en/busy high, waiting for rd_valid
//   DONE  | one-cycle done pulse; a new request may be accepted here
module dm_load_unit #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [3:0]  DEType,
  output logic        rd_en,
  output logic [31:0] rd_addr,
  input  logic        rd_valid,
  input  logic [31:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] data_out,
  output logic        adel,
  output logic        timeout
);

  localparam logic [3:0] LT_LW  = 4'b0001;
  localparam logic [3:0] LT_LBU = 4'b0010;
  localparam logic [3:0] LT_LB  = 4'b0011;
  localparam logic [3:0] LT_LHU = 4'b0100;
  localparam logic [3:0] LT_LH  = 4'b0101;

  // Last counter value that still counts as waiting; reaching it without
  // rd_valid abandons the read.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [1:0]  lat_b;
  logic [3:0]  lat_type;

  logic        type_legal;
  logic        misaligned;
  logic        accept;
  logic        reject;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext_data;

  // Decode the incoming request: legal load type and alignment check.
  always_comb begin
    type_legal = 1'b0;
    misaligned = 1'b0;
    case (DEType)
      LT_LW: begin
        type_legal = 1'b1;
        misaligned = (addr[1:0] != 2'b00);
      end
      LT_LHU, LT_LH: begin
        type_legal = 1'b1;
        misaligned = addr[0];
      end
      LT_LBU, LT_LB: begin
        type_legal = 1'b1;
        misaligned = 1'b0;
      end
      default: begin
        type_legal = 1'b0;
        misaligned = 1'b0;
      end
    endcase
    accept = req && type_legal && !misaligned;
    reject = req && type_legal && misaligned;
  end

  // Pick the addressed byte/halfword out of the returned word and extend it.
  always_comb begin
    case (lat_b)
      2'd0:    byte_sel = rd_data[7:0];
      2'd1:    byte_sel = rd_data[15:8];
      2'd2:    byte_sel = rd_data[23:16];
      default: byte_sel = rd_data[31:24];
    endcase
    half_sel = lat_b[1] ? rd_data[31:16] : rd_data[15:0];
    case (lat_type)
      LT_LW:   ext_data = rd_data;
      LT_LBU:  ext_data = {24'h000000, byte_sel};
      LT_LB:   ext_data = {{24{byte_sel[7]}}, byte_sel};
      LT_LHU:  ext_data = {16'h0000, half_sel};
      LT_LH:   ext_data = {{16{half_sel[15]}}, half_sel};
      default: ext_data = rd_data;
    endcase
  end

  // Sequencer: state, wait counter, latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= 8'd0;
      lat_b    <= 2'b00;
      lat_type <= 4'b0000;
      rd_en    <= 1'b0;
      rd_addr  <= 32'h0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= 32'h0;
      adel     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      done    <= 1'b0;
      adel    <= 1'b0;
      timeout <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state    <= S_WAIT;
            lat_b    <= addr[1:0];
            lat_type <= DEType;
            rd_addr  <= {addr[31:2], 2'b00};
            wait_cnt <= 8'd0;
            rd_en    <= 1'b1;
            busy     <= 1'b1;
          end else begin
            state <= S_IDLE;
            adel  <= reject;
          end
        end
        S_WAIT: begin
          // A response in the limit cycle still counts: rd_valid is checked first.
          if (rd_valid) begin
            state    <= S_DONE;
            data_out <= ext_data;
            done     <= 1'b1;
            rd_en    <= 1'b0;
            busy     <= 1'b0;
          end else if (wait_cnt == WAIT_LAST) begin
            state   <= S_IDLE;
            timeout <= 1'b1;
            rd_en   <= 1'b0;
            busy    <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          rd_en <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_load_unit.sv
// Testbench for dm_load_unit: directed scenarios plus randomized loads.
// The driver pushes the expected pulse (done/adel/timeout) and data_out into
// a queue at issue time; a monitor pops and compares on every output pulse.
module tb_dm_load_unit;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [31:0] addr;
  logic [3:0]  DEType;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        busy;
  logic        done;
  logic [31:0] data_out;
  logic        adel;
  logic        timeout;

  dm_load_unit #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .addr     (addr),
    .DEType   (DEType),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done),
    .data_out (data_out),
    .adel     (adel),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  kind;   // 0 done, 1 adel, 2 timeout
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_data = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference extraction computed with plain shifts and signed arithmetic.
  function automatic logic [31:0] ref_load(input logic [3:0] t, input int b, input logic [31:0] w);
    int v;
    case (t)
      4'd1: return w;
      4'd2, 4'd3: begin
        v = int'((w >> (8 * b)) & 32'hFF);
        if (t == 4'd3 && v > 127) v = v - 256;
        return 32'(v);
      end
      4'd4, 4'd5: begin
        v = int'((w >> (16 * (b / 2))) & 32'hFFFF);
        if (t == 4'd5 && v > 32767) v = v - 65536;
        return 32'(v);
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic string kind_name(input logic [1:0] k);
    case (k)
      2'd0: return "done";
      2'd1: return "adel";
      default: return "timeout";
    endcase
  endfunction

  // Drive one request in the current cycle and play the memory side.
  // lat = WAIT cycle in which rd_valid is returned; lat > MAX_WAIT = silent memory.
  // Leaves the bench just after the edge that ends the transaction.
  task automatic issue(input logic [3:0] t, input logic [31:0] a, input logic [31:0] word, input int lat);
    bit   legal;
    bit   aligned;
    exp_t e;
    legal = (t >= 4'd1 && t <= 4'd5);
    if (t == 4'd1)                    aligned = (a % 4 == 0);
    else if (t == 4'd4 || t == 4'd5)  aligned = (a % 2 == 0);
    else                              aligned = 1'b1;
    req = 1'b1; addr = a; DEType = t;
    if (!legal) begin
      step();
      req = 1'b0;
      check("ignored_no_read", {31'h0, rd_en}, 32'h0);
      return;
    end
    if (!aligned) begin
      e.kind = 2'd1; e.data = exp_data; exp_q.push_back(e);
      step();
      req = 1'b0;
      check("adel_no_read", {31'h0, rd_en}, 32'h0);
      return;
    end
    if (lat <= MAX_WAIT) begin
      exp_data = ref_load(t, int'(a[1:0]), word);
      e.kind = 2'd0;
    end else begin
      e.kind = 2'd2;
    end
    e.data = exp_data;
    exp_q.push_back(e);
    step();
    req = 1'b0; addr = $urandom; DEType = 4'($urandom);
    check("rd_en_after_accept", {31'h0, rd_en}, 32'h1);
    check("rd_addr", rd_addr, a & 32'hFFFF_FFFC);
    for (int k = 1; k <= lat && k <= MAX_WAIT; k++) begin
      check("busy_in_wait", {31'h0, busy}, 32'h1);
      rd_valid = (k == lat);
      rd_data  = (k == lat) ? word : $urandom;
      step();
    end
    rd_valid = 1'b0;
    if (lat > MAX_WAIT) begin
      check("rd_en_after_timeout", {31'h0, rd_en}, 32'h0);
      rd_valid = 1'b1; rd_data = $urandom;
      step();
      rd_valid = 1'b0;
    end else begin
      check("busy_after_done", {31'h0, busy}, 32'h0);
    end
  endtask

  // Monitor: every output pulse must match the oldest expected event.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1 && (adel === 1'b1 || timeout === 1'b1)) begin
        n_tests++; n_fail++;
        $display("FAIL pulse_overlap: done=%0b adel=%0b timeout=%0b, required done exclusive", done, adel, timeout);
      end
      if (done === 1'b1 || adel === 1'b1 || timeout === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_pulse: done=%0b adel=%0b timeout=%0b, required none", done, adel, timeout);
        end else begin
          e = exp_q.pop_front();
          n_tests++;
          if (!((e.kind == 2'd0 && done === 1'b1) || (e.kind == 2'd1 && adel === 1'b1) ||
                (e.kind == 2'd2 && timeout === 1'b1))) begin
            n_fail++;
            $display("FAIL pulse_kind: got done=%0b adel=%0b timeout=%0b, expected %s",
                     done, adel, timeout, kind_name(e.kind));
          end
          check({"data_out_", kind_name(e.kind)}, data_out, e.data);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] types [8];
    types = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd15};
    reset = 1'b1; req = 1'b0; addr = 32'h0; DEType = 4'h0; rd_valid = 1'b0; rd_data = 32'h0;
    step(2);
    check("reset_rd_en", {31'h0, rd_en}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_data_out", data_out, 32'h0);
    check("reset_pulses", {29'h0, done, adel, timeout}, 32'h0);
    reset = 1'b0;
    step();

    // lb, 3 WAIT cycles
    issue(4'd3, 32'h0000_1003, 32'h80FF_7F01, 3);
    check("lb_done", {31'h0, done}, 32'h1);
    check("lb_data", data_out, 32'hFFFF_FF80);
    step(2);

    // lhu then lh back-to-back, second accepted in the DONE cycle
    issue(4'd4, 32'h0000_2002, 32'h8001_FFFE, 2);
    check("lhu_data", data_out, 32'h0000_8001);
    issue(4'd5, 32'h0000_2000, 32'h8001_FFFE, 1);
    check("lh_data", data_out, 32'hFFFF_FFFE);
    step(2);

    // misaligned lw and lh
    issue(4'd1, 32'h0000_0006, 32'h0, 1);
    step();
    issue(4'd5, 32'h0000_0001, 32'h0, 1);
    step();
    check("adel_data_held", data_out, 32'hFFFF_FFFE);

    // silent memory -> timeout, late rd_valid ignored
    issue(4'd1, 32'h0000_3000, 32'hDEAD_BEEF, MAX_WAIT + 1);
    check("timeout_data_held", data_out, 32'hFFFF_FFFE);
    step();

    // reset on the 2nd WAIT cycle
    req = 1'b1; addr = 32'h0000_4000; DEType = 4'd1;
    step();
    req = 1'b0;
    step();
    check("mid_wait_busy", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_data = 32'h0;
    check("rst_rd_en", {31'h0, rd_en}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_pulses", {29'h0, done, adel, timeout}, 32'h0);
    check("rst_data_out", data_out, 32'h0);
    rd_valid = 1'b1; rd_data = 32'h1234_5678;
    step();
    rd_valid = 1'b0;
    check("late_valid_no_done", {31'h0, done}, 32'h0);
    step();

    // illegal type ignored, then lbu
    issue(4'd0, 32'h0000_5002, 32'hAABB_CCDD, 1);
    issue(4'd2, 32'h0000_5002, 32'hAABB_CCDD, 2);
    check("lbu_data", data_out, 32'h0000_00BB);
    step();

    // randomized loads
    for (int n = 0; n < 80; n++) begin
      issue(types[$urandom_range(0, 7)], $urandom, $urandom, int'($urandom_range(1, MAX_WAIT + 1)));
      step(int'($urandom_range(0, 2)));
    end

    step(3);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
